// File: rtl/write_burst_buffer_pkg.sv
// Shared state encodings, address field positions and constants for write_burst_buffer.
package write_burst_buffer_pkg;

    localparam int INSTR_ADDR_BUS = 32;
    localparam int LINE_MSB       = 31;
    localparam int LINE_LSB       = 7;
    localparam int BEAT_MSB       = 6;
    localparam int BEAT_LSB       = 3;
    localparam int CACHE_LINE_BUS = LINE_MSB - LINE_LSB + 1;

    localparam logic       RESET_EN = 1'b0;
    localparam logic [7:0] ZERO     = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/write_burst_buffer_ram_16_64_be.sv
// 16x64 data store: one byte-enabled synchronous write port, one asynchronous read port.
module ram_16_64_be (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wbe,
    input  logic [3:0]  raddr,
    output logic [63:0] rdata
);

    logic [63:0] mem [16];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/write_burst_buffer.sv
// Coalesces stores to one 128-byte line and drains it as a fixed 16-beat write burst.
// Optional idle-timeout drain is built when WBUF_TIMEOUT_EN is defined.
module write_burst_buffer
    import write_burst_buffer_pkg::*;
#(
    parameter int LINE_BEATS  = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wen,
    input  logic [INSTR_ADDR_BUS-1:0] waddr,
    input  logic [63:0]               wdata,
    input  logic [7:0]                wstrb,
    output logic                      wready,
    input  logic                      flush,
    output logic                      hit,
    output logic                      busy,
    output logic                      burst_addr_valid,
    input  logic                      burst_addr_ready,
    output logic [INSTR_ADDR_BUS-1:0] burst_base_addr,
    output logic                      burst_data_valid,
    input  logic                      burst_data_ready,
    output logic [63:0]               burst_data,
    output logic [7:0]                burst_strb,
    output logic [3:0]                burst_index,
    output logic                      burst_last,
    input  logic                      burst_resp_valid,
    output logic [2:0]                dbg_state
);

    // Bus handshakes: a transfer happens on a rising edge where valid && ready;
    // valid and its payload stay stable until then, ready may toggle freely.
    state_t                    state, state_next;
    logic [CACHE_LINE_BUS-1:0] line;
    logic [7:0]                strb_arr [LINE_BEATS];
    logic [3:0]                beat_cnt;
    logic [3:0]                beat_sel;
    logic                      same_line, accept, last_beat, timeout_hit;
    logic                      addr_hs, data_hs, resp_done;
    logic                      addr_unused;

    assign beat_sel    = waddr[BEAT_MSB:BEAT_LSB];
    assign same_line   = (waddr[LINE_MSB:LINE_LSB] == line);
    assign last_beat   = (beat_cnt == 4'(LINE_BEATS - 1));
    assign accept      = wready;
    assign addr_hs     = burst_addr_valid && burst_addr_ready;
    assign data_hs     = burst_data_valid && burst_data_ready;
    assign resp_done   = (state == ST_RESP) && burst_resp_valid;
    assign addr_unused = ^waddr[BEAT_LSB-1:0];

`ifdef WBUF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (rstn == RESET_EN)                   tmo_cnt <= '0;
        else if (state != ST_FILL || accept)    tmo_cnt <= '0;
        else                                    tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Drain on the edge that would bring the idle count to TIMEOUT_CYC-1.
    assign timeout_hit = (state == ST_FILL) && !accept &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYC - 2));
`else
    // No timer in this build: FILL leaves only on a line change or a flush.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (rstn == RESET_EN) begin
            state    <= ST_IDLE;
            line     <= '1;
            beat_cnt <= '0;
            for (int i = 0; i < LINE_BEATS; i++) strb_arr[i] <= ZERO;
        end else begin
            state <= state_next;
            if (resp_done) begin
                line <= '1;
                for (int i = 0; i < LINE_BEATS; i++) strb_arr[i] <= ZERO;
            end else if (accept) begin
                if (state == ST_IDLE) line <= waddr[LINE_MSB:LINE_LSB];
                strb_arr[beat_sel] <= strb_arr[beat_sel] | wstrb;
            end
            if (addr_hs)      beat_cnt <= '0;
            else if (data_hs) beat_cnt <= beat_cnt + 4'd1;
        end
    end

    always_comb begin
        state_next       = state;
        wready           = 1'b0;
        burst_addr_valid = 1'b0;
        burst_data_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                wready = wen;
                if (wen) state_next = ST_FILL;
            end
            ST_FILL: begin
                // A same-line store merges even when a flush arrives with it.
                wready = wen && same_line;
                if ((wen && !same_line) || flush || timeout_hit) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                burst_addr_valid = 1'b1;
                if (burst_addr_ready) state_next = ST_DATA;
            end
            ST_DATA: begin
                burst_data_valid = 1'b1;
                if (burst_data_ready && last_beat) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (burst_resp_valid) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (rstn == RESET_EN) wready = 1'b0;
    end

    ram_16_64_be u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (beat_sel),
        .wdata (wdata),
        .wbe   (wstrb),
        .raddr (beat_cnt),
        .rdata (burst_data)
    );

    assign hit             = (state != ST_IDLE) && same_line;
    assign busy            = (state != ST_IDLE);
    assign burst_base_addr = {line, 7'b0};
    assign burst_strb      = strb_arr[beat_cnt];
    assign burst_index     = beat_cnt;
    assign burst_last      = (state == ST_DATA) && last_beat;
    assign dbg_state       = state;

endmodule

// File: tb/tb_write_burst_buffer.sv
// Self-checking bench for write_burst_buffer: reference line model plus a beat scoreboard.
module tb_write_burst_buffer;

    localparam int BW = 77;

    logic        clk;
    logic        rstn;
    logic        wen;
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wready;
    logic        flush;
    logic        hit;
    logic        busy;
    logic        burst_addr_valid;
    logic        burst_addr_ready;
    logic [31:0] burst_base_addr;
    logic        burst_data_valid;
    logic        burst_data_ready;
    logic [63:0] burst_data;
    logic [7:0]  burst_strb;
    logic [3:0]  burst_index;
    logic        burst_last;
    logic        burst_resp_valid;
    logic [2:0]  dbg_state;

    write_burst_buffer dut (
        .clk              (clk),
        .rstn             (rstn),
        .wen              (wen),
        .waddr            (waddr),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .wready           (wready),
        .flush            (flush),
        .hit              (hit),
        .busy             (busy),
        .burst_addr_valid (burst_addr_valid),
        .burst_addr_ready (burst_addr_ready),
        .burst_base_addr  (burst_base_addr),
        .burst_data_valid (burst_data_valid),
        .burst_data_ready (burst_data_ready),
        .burst_data       (burst_data),
        .burst_strb       (burst_strb),
        .burst_index      (burst_index),
        .burst_last       (burst_last),
        .burst_resp_valid (burst_resp_valid),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model and scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mon_exp, mon_got;
    logic [63:0]   ref_data [16];
    logic [7:0]    ref_strb [16];
    logic [24:0]   ref_line;
    logic          ref_fill;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] strb_mask(input logic [7:0] s);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{s[k]}};
        return m;
    endfunction

    task automatic model_merge(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int b;
        b = int'(a[6:3]);
        for (int k = 0; k < 8; k++) if (s[k]) ref_data[b][k*8 +: 8] = d[k*8 +: 8];
        ref_strb[b] = ref_strb[b] | s;
        ref_line    = a[31:7];
        ref_fill    = 1'b1;
    endtask

    task automatic model_clear();
        ref_fill = 1'b0;
        for (int i = 0; i < 16; i++) ref_strb[i] = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rstn && burst_data_valid && burst_data_ready) begin
            check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = {burst_index, burst_strb, burst_last, burst_data & strb_mask(burst_strb)};
                check("beat", 128'(mon_got), 128'(mon_exp));
            end
            beats_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                         input logic fl);
        logic exp_hit, exp_acc;
        exp_hit = ref_fill && (a[31:7] == ref_line);
        exp_acc = !ref_fill || exp_hit;
        waddr = a; wdata = d; wstrb = s; wen = 1'b1; flush = fl;
        #1;
        check("store_wready", 128'(wready), 128'(exp_acc));
        check("store_hit", 128'(hit), 128'(exp_hit));
        tick();
        wen = 1'b0; flush = 1'b0;
        if (exp_acc) model_merge(a, d, s);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready toggles 1-0-1, 2: random ready
    task automatic run_burst(input int mode, input int abort_at, output bit aborted);
        int start, cyc;
        aborted = 1'b0;
        for (int i = 0; i < 16; i++)
            exp_q.push_back({4'(i), ref_strb[i], (i == 15), ref_data[i] & strb_mask(ref_strb[i])});
        cyc = 0;
        while (!burst_addr_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("addr_valid", 128'(burst_addr_valid), 128'(1));
        check("base_addr", 128'(burst_base_addr), 128'({ref_line, 7'b0}));
        check("wready_in_addr", 128'(wready), 128'(0));
        tick();
        check("addr_hold", 128'(burst_addr_valid), 128'(1));
        burst_addr_ready = 1'b1;
        tick();
        burst_addr_ready = 1'b0;
        check("first_beat_valid", 128'(burst_data_valid), 128'(1));
        check("first_beat_index", 128'(burst_index), 128'(0));
        start = beats_seen;
        cyc   = 0;
        while ((beats_seen - start) < 16 && cyc < 200) begin
            if (abort_at >= 0 && int'(burst_index) == abort_at) begin
                aborted = 1'b1;
                break;
            end
            case (mode)
                0:       burst_data_ready = 1'b1;
                1:       burst_data_ready = ((cyc % 2) == 0);
                default: burst_data_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        burst_data_ready = 1'b0;
        if (aborted) return;
        check("beat_count", 128'(beats_seen - start), 128'(16));
        check("resp_busy", 128'(busy), 128'(1));
        check("resp_no_beat", 128'(burst_data_valid), 128'(0));
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        burst_resp_valid = 1'b1;
        tick();
        burst_resp_valid = 1'b0;
        check("idle_after_resp", 128'(busy), 128'(0));
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ab;
        rstn = 1'b0; wen = 1'b1; waddr = 32'h8000_0000; wdata = '0; wstrb = '0;
        flush = 1'b0; burst_addr_ready = 1'b0; burst_data_ready = 1'b0; burst_resp_valid = 1'b0;
        ref_line = '1;
        model_clear();
        repeat (2) tick();
        check("rst_state", 128'(dbg_state), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wready", 128'(wready), 128'(0));
        check("rst_addr_valid", 128'(burst_addr_valid), 128'(0));
        check("rst_data_valid", 128'(burst_data_valid), 128'(0));
        check("rst_last", 128'(burst_last), 128'(0));
        check("rst_hit", 128'(hit), 128'(0));
        wen = 1'b0;
        rstn = 1'b1;
        tick();

        // single beat written, rest of the line empty
        store(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);
        do_flush();
        run_burst(0, -1, ab);

        // two half-stores merge into one beat
        store(32'h8000_0010, 64'hAAAA_AAAA_1122_3344, 8'h0F, 1'b0);
        store(32'h8000_0010, 64'h5566_7788_BBBB_BBBB, 8'hF0, 1'b0);
        do_flush();
        run_burst(2, -1, ab);

        // different-line store stalls, drains the held line, then is accepted
        store(32'h8000_0000, 64'h0102_0304_0506_0708, 8'h3C, 1'b0);
        waddr = 32'h8000_0080; wdata = 64'hCAFE_F00D_DEAD_BEEF; wstrb = 8'hFF; wen = 1'b1;
        #1;
        check("miss_wready", 128'(wready), 128'(0));
        check("miss_hit", 128'(hit), 128'(0));
        run_burst(1, -1, ab);
        check("held_store_wready", 128'(wready), 128'(1));
        tick();
        wen = 1'b0;
        model_merge(32'h8000_0080, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
        waddr = 32'h8000_00C0;
        #1;
        check("hit_new_line", 128'(hit), 128'(1));
        do_flush();
        run_burst(1, -1, ab);

        // flush together with a same-line store: store merges before the drain
        store(32'h8000_0200, 64'h1111_2222_3333_4444, 8'hC3, 1'b0);
        store(32'h8000_0218, 64'h9999_8888_7777_6666, 8'h81, 1'b1);
        run_burst(0, -1, ab);

        // flush while idle does nothing
        do_flush();
        repeat (3) tick();
        check("idle_flush_busy", 128'(busy), 128'(0));
        check("idle_flush_addr", 128'(burst_addr_valid), 128'(0));

        // random line fills drained with random ready
        for (int r = 0; r < 3; r++) begin
            logic [31:0] base;
            int n;
            base = $urandom() & 32'hFFFF_FF80;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++)
                store({base[31:7], 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))},
                      {$urandom(), $urandom()}, 8'($urandom_range(0, 255)), 1'b0);
            do_flush();
            run_burst(2, -1, ab);
        end

        // reset in the middle of beat 7 abandons the burst
        store(32'h9000_0010, {$urandom(), $urandom()}, 8'hFF, 1'b0);
        store(32'h9000_0038, {$urandom(), $urandom()}, 8'h0F, 1'b0);
        do_flush();
        run_burst(0, 7, ab);
        check("abort_reached", 128'(ab), 128'(1));
        rstn = 1'b0;
        wen  = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_data_valid", 128'(burst_data_valid), 128'(0));
        check("midrst_addr_valid", 128'(burst_addr_valid), 128'(0));
        check("midrst_wready", 128'(wready), 128'(0));
        check("midrst_last", 128'(burst_last), 128'(0));
        exp_q.delete();
        tick();
        wen  = 1'b0;
        rstn = 1'b1;
        model_clear();
        tick();
        check("postrst_busy", 128'(busy), 128'(0));
        do_flush();
        repeat (4) tick();
        check("postrst_no_burst", 128'(burst_addr_valid), 128'(0));
        check("postrst_idle", 128'(busy), 128'(0));

        // idle timeout
        store(32'h8000_0100, 64'h0F0E_0D0C_0B0A_0908, 8'h01, 1'b0);
`ifdef WBUF_TIMEOUT_EN
        repeat (62) tick();
        check("tmo_not_yet", 128'(burst_addr_valid), 128'(0));
        tick();
        check("tmo_fire", 128'(burst_addr_valid), 128'(1));
`else
        repeat (100) tick();
        check("no_tmo_addr", 128'(burst_addr_valid), 128'(0));
        check("no_tmo_busy", 128'(busy), 128'(1));
        do_flush();
`endif
        run_burst(0, -1, ab);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
